// File: rtl/alu_cc_seq.sv
// Execute-stage ALU with registered result, valid/ready handshakes and a CC register.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (fun 100) and its MUL state.
module alu_cc_seq #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       aluFun,
  input  logic             set_cc,
  input  logic [WIDTH-1:0] aluA,
  input  logic [WIDTH-1:0] aluB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] valE,
  output logic             ZF,
  output logic             SF,
  output logic             OF,
  output logic             busy
);

  localparam int MSB = WIDTH - 1;
  localparam logic [2:0] FUN_ADD = 3'b000;
  localparam logic [2:0] FUN_SUB = 3'b001;
  localparam logic [2:0] FUN_AND = 3'b010;
  localparam logic [2:0] FUN_XOR = 3'b011;
`ifdef ALU_MUL_EN
  localparam logic [2:0] FUN_MUL = 3'b100;
`endif

  if (2**CNT_W <= WIDTH) begin : g_cnt_w_check
    $error("alu_cc_seq: CNT_W too narrow to count WIDTH multiply steps");
  end

  // Handshake: a request transfers on a rising edge where in_valid && in_ready;
  // a result transfers on a rising edge where out_valid && out_ready.
  logic [WIDTH-1:0] valE_q, valE_d;
  logic             out_valid_q, out_valid_d;
  logic             zf_q, zf_d, sf_q, sf_d, of_q, of_d;
  logic             idle;
  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic             alu_of;
  logic             alu_cc_ok;

`ifdef ALU_MUL_EN
  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_e;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             setcc_q, setcc_d;

  assign idle = (state_q == S_IDLE);
  assign busy = (state_q == S_MUL);
`else
  assign idle = 1'b1;
  assign busy = 1'b0;
`endif

  // in_ready stays low while reset is held.
  assign in_ready = rst_n && idle && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    alu_res   = '0;
    alu_of    = 1'b0;
    alu_cc_ok = 1'b1;
    case (aluFun)
      FUN_ADD: begin
        alu_res = aluB + aluA;
        alu_of  = (aluA[MSB] == aluB[MSB]) && (alu_res[MSB] != aluA[MSB]);
      end
      FUN_SUB: begin
        alu_res = aluB - aluA;
        alu_of  = (aluA[MSB] != aluB[MSB]) && (alu_res[MSB] != aluB[MSB]);
      end
      FUN_AND: alu_res = aluB & aluA;
      FUN_XOR: alu_res = aluB ^ aluA;
      default: alu_cc_ok = 1'b0;
    endcase
  end

  always_comb begin
    valE_d      = valE_q;
    out_valid_d = out_valid_q;
    zf_d        = zf_q;
    sf_d        = sf_q;
    of_d        = of_q;
`ifdef ALU_MUL_EN
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    setcc_d  = setcc_q;
    acc_sum  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

`ifdef ALU_MUL_EN
    if (state_q == S_MUL) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        state_d     = S_IDLE;
        valE_d      = acc_sum;
        out_valid_d = 1'b1;
        if (setcc_q) begin
          zf_d = (acc_sum == '0);
          sf_d = acc_sum[MSB];
          of_d = 1'b0;
        end
      end
    end else
`endif
    if (accept) begin
`ifdef ALU_MUL_EN
      if (aluFun == FUN_MUL) begin
        state_d  = S_MUL;
        mcand_d  = aluA;
        mplier_d = aluB;
        acc_d    = '0;
        cnt_d    = '0;
        setcc_d  = set_cc;
      end else
`endif
      begin
        valE_d      = alu_res;
        out_valid_d = 1'b1;
        if (set_cc && alu_cc_ok) begin
          zf_d = (alu_res == '0);
          sf_d = alu_res[MSB];
          of_d = alu_of;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valE_q      <= '0;
      out_valid_q <= 1'b0;
      zf_q        <= 1'b1;
      sf_q        <= 1'b0;
      of_q        <= 1'b0;
`ifdef ALU_MUL_EN
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      setcc_q  <= 1'b0;
`endif
    end else begin
      valE_q      <= valE_d;
      out_valid_q <= out_valid_d;
      zf_q        <= zf_d;
      sf_q        <= sf_d;
      of_q        <= of_d;
`ifdef ALU_MUL_EN
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      setcc_q  <= setcc_d;
`endif
    end
  end

  assign valE      = valE_q;
  assign out_valid = out_valid_q;
  assign ZF        = zf_q;
  assign SF        = sf_q;
  assign OF        = of_q;

endmodule

// File: tb/tb_alu_cc_seq.sv
// Directed self-checking bench for alu_cc_seq (WIDTH=64); honours ALU_MUL_EN when defined.
module tb_alu_cc_seq;

  localparam logic [2:0] F_ADD = 3'b000;
  localparam logic [2:0] F_SUB = 3'b001;
  localparam logic [2:0] F_AND = 3'b010;
  localparam logic [2:0] F_XOR = 3'b011;
  localparam logic [2:0] F_MUL = 3'b100;
  localparam logic [2:0] F_RSV = 3'b110;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  aluFun;
  logic        set_cc;
  logic [63:0] aluA;
  logic [63:0] aluB;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] valE;
  logic        ZF, SF, OF;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  alu_cc_seq #(.WIDTH(64), .CNT_W(7)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .aluFun   (aluFun),
    .set_cc   (set_cc),
    .aluA     (aluA),
    .aluB     (aluB),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .valE     (valE),
    .ZF       (ZF),
    .SF       (SF),
    .OF       (OF),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] f, input logic sc,
                       input logic [63:0] a, input logic [63:0] b);
    in_valid = v;
    aluFun   = f;
    set_cc   = sc;
    aluA     = a;
    aluB     = b;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_cc(input string tag, input logic z, input logic s, input logic o);
    chk1({tag, "_zf"}, ZF, z);
    chk1({tag, "_sf"}, SF, s);
    chk1({tag, "_of"}, OF, o);
  endtask

  initial begin
    int n;
    int busy_n;
    int bad;

    // Reset
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, F_ADD, 1'b0, 64'd0, 64'd0);
    step();
    step();
    chk("rst_valE", valE, 64'd0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk_cc("rst", 1'b1, 1'b0, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    step();
    chk1("rel_in_ready", in_ready, 1'b1);

    // Add with signed overflow
    drive(1'b1, F_ADD, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    step();
    chk("add_ovf_valE", valE, 64'h8000_0000_0000_0000);
    chk1("add_ovf_out_valid", out_valid, 1'b1);
    chk_cc("add_ovf", 1'b0, 1'b1, 1'b1);

    // Sub to zero, back-to-back xor without CC update
    drive(1'b1, F_SUB, 1'b1, 64'd5, 64'd5);
    step();
    chk("sub_zero_valE", valE, 64'd0);
    chk_cc("sub_zero", 1'b1, 1'b0, 1'b0);
    drive(1'b1, F_XOR, 1'b0, 64'hF0, 64'h0F);
    step();
    chk("xor_valE", valE, 64'hFF);
    chk1("xor_out_valid", out_valid, 1'b1);
    chk_cc("xor_hold", 1'b1, 1'b0, 1'b0);

    drive(1'b1, F_AND, 1'b1, 64'hFF00, 64'h0FF0);
    step();
    chk("and_valE", valE, 64'h0F00);
    chk_cc("and", 1'b0, 1'b0, 1'b0);

    // Add wraps to zero: mixed signs, no overflow
    drive(1'b1, F_ADD, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    step();
    chk("add_wrap_valE", valE, 64'd0);
    chk_cc("add_wrap", 1'b1, 1'b0, 1'b0);

    // Sub overflow: most-negative minus one
    drive(1'b1, F_SUB, 1'b1, 64'd1, 64'h8000_0000_0000_0000);
    step();
    chk("sub_ovf_valE", valE, 64'h7FFF_FFFF_FFFF_FFFF);
    chk_cc("sub_ovf", 1'b0, 1'b0, 1'b1);

    // Reserved code: zero result, CC held despite set_cc
    drive(1'b1, F_RSV, 1'b1, 64'd5, 64'd7);
    step();
    chk("rsv_valE", valE, 64'd0);
    chk1("rsv_out_valid", out_valid, 1'b1);
    chk_cc("rsv_hold", 1'b0, 1'b0, 1'b1);

    drive(1'b0, F_ADD, 1'b0, 64'd0, 64'd0);
    step();
    chk1("drain_out_valid", out_valid, 1'b0);

    // Multiply
    drive(1'b1, F_MUL, 1'b1, 64'h1_0000_0001, 64'd3);
    step();
`ifdef ALU_MUL_EN
    chk1("mul_busy", busy, 1'b1);
    chk1("mul_in_ready", in_ready, 1'b0);
    chk1("mul_out_valid", out_valid, 1'b0);
    drive(1'b1, F_ADD, 1'b1, 64'd1, 64'd1);
    n      = 1;
    busy_n = 1;
    while (!out_valid && n < 200) begin
      if (n == 4) in_valid = 1'b0;
      step();
      n++;
      if (busy) busy_n++;
    end
    chk("mul_latency", 64'(n), 64'd65);
    chk("mul_busy_cycles", 64'(busy_n), 64'd64);
    chk1("mul_done_busy", busy, 1'b0);
    chk("mul_valE", valE, 64'h3_0000_0003);
    chk_cc("mul", 1'b0, 1'b0, 1'b0);
`else
    chk1("mul_off_busy", busy, 1'b0);
    chk1("mul_off_out_valid", out_valid, 1'b1);
    chk("mul_off_valE", valE, 64'd0);
    chk_cc("mul_off_hold", 1'b0, 1'b0, 1'b1);
`endif
    drive(1'b0, F_ADD, 1'b0, 64'd0, 64'd0);
    step();
    chk1("mul_drain_out_valid", out_valid, 1'b0);

    // Backpressure
    out_ready = 1'b0;
    drive(1'b1, F_ADD, 1'b0, 64'd2, 64'd3);
    step();
    chk("bp_first_valE", valE, 64'd5);
    chk1("bp_first_out_valid", out_valid, 1'b1);
    drive(1'b1, F_ADD, 1'b0, 64'd10, 64'd20);
    for (int i = 0; i < 10; i++) begin
      step();
      chk1("bp_in_ready", in_ready, 1'b0);
      chk("bp_valE_stable", valE, 64'd5);
      chk1("bp_out_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    #1;
    chk1("bp_release_in_ready", in_ready, 1'b1);
    step();
    chk("bp_second_valE", valE, 64'd30);
    chk1("bp_second_out_valid", out_valid, 1'b1);
    drive(1'b0, F_ADD, 1'b0, 64'd0, 64'd0);
    step();
    chk1("bp_drain_out_valid", out_valid, 1'b0);

    // Reset in the middle of an operation
`ifdef ALU_MUL_EN
    drive(1'b1, F_MUL, 1'b1, 64'd3, 64'd5);
    step();
    drive(1'b0, F_ADD, 1'b0, 64'd0, 64'd0);
    for (int i = 0; i < 19; i++) step();
    chk1("pre_rst_busy", busy, 1'b1);
`else
    drive(1'b1, F_ADD, 1'b1, 64'h8000_0000_0000_0000, 64'd0);
    step();
    drive(1'b0, F_ADD, 1'b0, 64'd0, 64'd0);
    chk_cc("pre_rst", 1'b0, 1'b1, 1'b0);
`endif
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_valE", valE, 64'd0);
    chk_cc("mid_rst", 1'b1, 1'b0, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_in_ready", in_ready, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    bad = 0;
    for (int i = 0; i < 70; i++) begin
      if (out_valid || busy) bad++;
      step();
    end
    chk("post_rst_no_result", 64'(bad), 64'd0);
    chk_cc("post_rst", 1'b1, 1'b0, 1'b0);
    chk1("post_rst_in_ready", in_ready, 1'b1);
    drive(1'b1, F_ADD, 1'b1, 64'd1, 64'd2);
    step();
    drive(1'b0, F_ADD, 1'b0, 64'd0, 64'd0);
    chk("post_rst_add_valE", valE, 64'd3);
    chk_cc("post_rst_add", 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
